// File: rtl/tinyalu_pkg.sv
// Shared types for the parametrised tiny ALU: opcode encoding and controller states.
// Also holds the helper that tells the controller which opcodes use the multiplier pipe.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ADD  = 3'd1,
        AND  = 3'd2,
        XOR  = 3'd3,
        MULT = 3'd4,
        SUB  = 3'd5,
        OR   = 3'd6,
        MAC  = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } alu_state_t;

    function automatic logic uses_mult(input operation_t o);
        return (o == MULT) || (o == MAC);
    endfunction

endpackage

// File: rtl/tinyalu_mult_pipe.sv
// Unsigned WIDTH x WIDTH multiplier followed by MULT_LAT-1 register stages.
// MULT and MAC share this pipe.
module tinyalu_mult_pipe #(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int STAGES = MULT_LAT - 1;

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] stage_q [STAGES];

    assign a_ext = {{WIDTH{1'b0}}, a_i};
    assign b_ext = {{WIDTH{1'b0}}, b_i};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= a_ext * b_ext;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign prod_o = stage_q[STAGES-1];

endmodule

// File: rtl/tinyalu_param.sv
// Parametrised tiny ALU: start/done handshake, single-cycle logic ops, pipelined MULT/MAC.
// state | meaning: IDLE waits for start; EXEC counts down latency; HOLD waits for start low.
module tinyalu_param
    import tinyalu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int CW = $clog2(MULT_LAT + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    alu_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    operation_t           op_q, op_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    operation_t           op_in;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   mac_sum;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [2*WIDTH-1:0]   alu_out;

    assign op_in = operation_t'(op);

    tinyalu_mult_pipe #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT)
    ) u_mult_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .a_i     (a_q),
        .b_i     (b_q),
        .prod_o  (prod)
    );

    // SUB keeps the borrow in bit WIDTH by subtracting in WIDTH+1 bits.
    assign add_w   = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w   = {1'b0, a_q} - {1'b0, b_q};
    assign mac_sum = acc_q + prod;

    always_comb begin
        alu_out = '0;
        case (op_q)
            ADD:     alu_out = {{(WIDTH-1){1'b0}}, add_w};
            SUB:     alu_out = {{(WIDTH-1){1'b0}}, sub_w};
            AND:     alu_out = {{WIDTH{1'b0}}, a_q & b_q};
            XOR:     alu_out = {{WIDTH{1'b0}}, a_q ^ b_q};
            OR:      alu_out = {{WIDTH{1'b0}}, a_q | b_q};
            MULT:    alu_out = prod;
            MAC:     alu_out = mac_sum;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_in == NOP) begin
                        acc_d = '0;
                    end else begin
                        a_d     = A;
                        b_d     = B;
                        op_d    = op_in;
                        cnt_d   = uses_mult(op_in) ? MULT_CNT : '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    result_d = alu_out;
                    done_d   = 1'b1;
                    state_d  = HOLD;
                    if (op_q == MAC) begin
                        acc_d = mac_sum;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= NOP;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign busy   = (state_q == EXEC);

endmodule
